// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding and load-use detection.
//   Captures the decoded instruction each cycle (unless stalled or flushed),
//   then builds the ALU operands combinationally from the registered state
//   and the EX/MEM and MEM/WB forwarding paths.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   stall, flush          : hold ID/EX / load a bubble (flush wins over stall)
//   id_*                  : decoded instruction, operands and control
//   exmem_*, memwb_*      : forwarding sources (regwrite, rd, result)
//   inputA, inputB, aluc  : ALU operands and function code
//   ex_valid, ex_rd,
//   ex_regwrite,
//   ex_memread            : registered EX-stage control
//   ex_store_data         : forwarded rt value for stores
//   load_use_hazard       : EX holds a load whose rd is needed by ID
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [FUNC_W-1:0] id_aluc,
  input  logic              id_alusrc,
  input  logic              id_shift,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              exmem_regwrite,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] inputA,
  output logic [DATA_W-1:0] inputB,
  output logic [FUNC_W-1:0] aluc,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_hazard
);

  localparam logic [FUNC_W-1:0] ALUC_ADD = FUNC_W'(6'b100000);

  // ID/EX state
  logic              valid_r;
  logic [DATA_W-1:0] rs_data_r;
  logic [DATA_W-1:0] rt_data_r;
  logic [DATA_W-1:0] imm_r;
  logic [4:0]        shamt_r;
  logic [4:0]        rs_r;
  logic [4:0]        rt_r;
  logic [4:0]        rd_r;
  logic [FUNC_W-1:0] aluc_r;
  logic              alusrc_r;
  logic              shift_r;
  logic              regwrite_r;
  logic              memread_r;

  logic [DATA_W-1:0] fwd_a_s;
  logic [DATA_W-1:0] fwd_b_s;

  // Forwarding select: EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] forward_sel(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] raw,
    input logic              em_we,
    input logic [4:0]        em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [4:0]        mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] sel;
    if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
      sel = em_res;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
      sel = mw_res;
    end else begin
      sel = raw;
    end
    return sel;
  endfunction

  // Pipeline register: reset and flush both load the bubble (which is the
  // reset state), flush overriding stall; otherwise capture unless stalled.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_r    <= 1'b0;
      rs_data_r  <= '0;
      rt_data_r  <= '0;
      imm_r      <= '0;
      shamt_r    <= 5'd0;
      rs_r       <= 5'd0;
      rt_r       <= 5'd0;
      rd_r       <= 5'd0;
      aluc_r     <= ALUC_ADD;
      alusrc_r   <= 1'b0;
      shift_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
    end else if (!stall) begin
      valid_r    <= id_valid;
      rs_data_r  <= id_rs_data;
      rt_data_r  <= id_rt_data;
      imm_r      <= id_imm;
      shamt_r    <= id_shamt;
      rs_r       <= id_rs;
      rt_r       <= id_rt;
      rd_r       <= id_rd;
      aluc_r     <= id_aluc;
      alusrc_r   <= id_alusrc;
      shift_r    <= id_shift;
      regwrite_r <= id_regwrite;
      memread_r  <= id_memread;
    end
  end

  // Forwarded operands and ALU input muxing, no extra cycle.
  always_comb begin
    fwd_a_s = forward_sel(rs_r, rs_data_r, exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result);
    fwd_b_s = forward_sel(rt_r, rt_data_r, exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result);
    if (shift_r) begin
      inputA = {{(DATA_W-5){1'b0}}, shamt_r};
    end else begin
      inputA = fwd_a_s;
    end
    if (alusrc_r) begin
      inputB = imm_r;
    end else begin
      inputB = fwd_b_s;
    end
    // Stores always need the real rt value, even when B carries the offset.
    ex_store_data = fwd_b_s;
  end

  // Load-use: a load in EX whose destination is a source of the ID instruction.
  always_comb begin
    load_use_hazard = valid_r & memread_r & (rd_r != 5'd0) &
                      ((rd_r == id_rs) | (rd_r == id_rt));
  end

  assign aluc        = aluc_r;
  assign ex_valid    = valid_r;
  assign ex_rd       = rd_r;
  assign ex_regwrite = regwrite_r;
  assign ex_memread  = memread_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: directed scenarios with literal
//   expectations, then randomized stimulus compared every cycle against a
//   behavioural model of the ID/EX contents and the forwarding rules.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [5:0]  id_aluc;
  logic        id_alusrc, id_shift, id_regwrite, id_memread;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] inputA, inputB, ex_store_data;
  logic [5:0]  aluc;
  logic        ex_valid, ex_regwrite, ex_memread, load_use_hazard;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage #(.DATA_W(32), .FUNC_W(6)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_aluc(id_aluc), .id_alusrc(id_alusrc),
    .id_shift(id_shift), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .inputA(inputA), .inputB(inputB), .aluc(aluc), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // Model of what the EX stage currently holds
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [5:0]  aluc;
    logic        alusrc, shift, regwrite, memread;
  } ex_t;

  ex_t m;
  bit  m_known = 1'b0;

  function automatic ex_t bubble();
    ex_t b;
    b = '0;
    b.aluc = 6'b100000;
    return b;
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] src, input logic [31:0] raw);
    if (src == 5'd0) return raw;
    if (exmem_regwrite && exmem_rd == src) return exmem_result;
    if (memwb_regwrite && memwb_rd == src) return memwb_result;
    return raw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock edge; the model follows the same edge using the driven inputs.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m = bubble();
      m_known = 1'b1;
    end else if (flush) begin
      m = bubble();
    end else if (!stall) begin
      m.valid = id_valid;     m.rs_data = id_rs_data; m.rt_data = id_rt_data;
      m.imm = id_imm;         m.shamt = id_shamt;     m.rs = id_rs;
      m.rt = id_rt;           m.rd = id_rd;           m.aluc = id_aluc;
      m.alusrc = id_alusrc;   m.shift = id_shift;     m.regwrite = id_regwrite;
      m.memread = id_memread;
    end
    #1;
  endtask

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (m_known) begin
      check("m_inputA", inputA, m.shift ? {27'd0, m.shamt} : exp_fwd(m.rs, m.rs_data));
      check("m_inputB", inputB, m.alusrc ? m.imm : exp_fwd(m.rt, m.rt_data));
      check("m_store", ex_store_data, exp_fwd(m.rt, m.rt_data));
      check("m_aluc", {26'd0, aluc}, {26'd0, m.aluc});
      check("m_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      check("m_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      check("m_regwrite", {31'd0, ex_regwrite}, {31'd0, m.regwrite});
      check("m_memread", {31'd0, ex_memread}, {31'd0, m.memread});
      check("m_hazard", {31'd0, load_use_hazard},
            {31'd0, m.valid && m.memread && m.rd != 5'd0 && (m.rd == id_rs || m.rd == id_rt)});
    end
  end

  task automatic clear_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    id_shamt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_aluc = 6'b100000; id_alusrc = 1'b0; id_shift = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Reset state
    check("rst_inputA", inputA, 32'd0);
    check("rst_inputB", inputB, 32'd0);
    check("rst_aluc", {26'd0, aluc}, 32'h20);
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("rst_hazard", {31'd0, load_use_hazard}, 32'd0);

    // Basic capture
    id_valid = 1'b1; id_rs_data = 32'd5; id_rt_data = 32'd7; id_rs = 5'd1;
    id_rt = 5'd2; id_rd = 5'd3; id_regwrite = 1'b1; id_aluc = 6'b100000;
    tick();
    check("cap_inputA", inputA, 32'd5);
    check("cap_inputB", inputB, 32'd7);
    check("cap_aluc", {26'd0, aluc}, 32'h20);
    check("cap_valid", {31'd0, ex_valid}, 32'd1);

    // Forward priority
    id_rs = 5'd3; id_rs_data = 32'h11;
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    #1 check("fwd_exmem", inputA, 32'hAA);
    exmem_regwrite = 1'b0;
    #1 check("fwd_memwb", inputA, 32'hBB);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 check("fwd_r0", inputA, 32'h11);
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;

    // Shift amount / immediate / store data
    id_shift = 1'b1; id_shamt = 5'd4; id_alusrc = 1'b1; id_imm = 32'h10;
    id_rt = 5'd5; id_rt_data = 32'h1234;
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h99;
    #1 check("sh_inputA", inputA, 32'd4);
    check("imm_inputB", inputB, 32'h10);
    check("st_data", ex_store_data, 32'h99);
    exmem_regwrite = 1'b0; exmem_rd = 5'd0;
    id_shift = 1'b0; id_alusrc = 1'b0;

    // Load-use hazard
    id_memread = 1'b1; id_rd = 5'd8; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    id_memread = 1'b0; id_rs = 5'd8; id_rt = 5'd0;
    #1 check("lu_rs", {31'd0, load_use_hazard}, 32'd1);
    id_rs = 5'd9; id_rt = 5'd8;
    #1 check("lu_rt", {31'd0, load_use_hazard}, 32'd1);
    id_rt = 5'd9;
    #1 check("lu_none", {31'd0, load_use_hazard}, 32'd0);
    id_rs = 5'd8;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("lu_fl_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_fl_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("lu_fl_hazard", {31'd0, load_use_hazard}, 32'd0);

    // Stall / flush / reset priority
    id_rs = 5'd10; id_rt = 5'd11; id_rd = 5'd12; id_rs_data = 32'h55;
    id_rt_data = 32'h66; id_aluc = 6'b100010;
    tick();
    stall = 1'b1; id_rs_data = 32'h77; id_rt_data = 32'h88; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_inputA", inputA, 32'h55);
      check("stall_inputB", inputB, 32'h66);
      check("stall_valid", {31'd0, ex_valid}, 32'd1);
    end
    flush = 1'b1;
    tick();
    check("sf_valid", {31'd0, ex_valid}, 32'd0);
    check("sf_aluc", {26'd0, aluc}, 32'h20);
    check("sf_inputA", inputA, 32'd0);
    stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    check("rf_valid", {31'd0, ex_valid}, 32'd0);
    check("rf_aluc", {26'd0, aluc}, 32'h20);
    check("rf_inputB", inputB, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 4) == 0);
      id_valid = 1'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
      id_imm = $urandom; id_shamt = 5'($urandom);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7)); id_aluc = 6'($urandom);
      id_alusrc = 1'($urandom); id_shift = 1'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
